// File: rtl/coin_pkg.sv
// Shared coin-path types: denomination codes and the occlusion-measure FSM states.
package coin_pkg;

    localparam int COIN_TYPE_BITS = 3;

    typedef enum logic [COIN_TYPE_BITS-1:0] {
        NONE = 3'd0,
        C5   = 3'd1,
        C10  = 3'd2,
        C25  = 3'd3,
        D1   = 3'd4,
        D2   = 3'd5
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_CLASS,
        ST_JAM
    } meas_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Return-button conditioner: 2-flop sync, DEB_CYC-cycle stability filter, rising-edge pulse.
// Latency 2 + DEB_CYC cycles from raw press to press_o; no backpressure.
module coin_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                // Level accepted after DEB_CYC consecutive differing cycles.
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/coin_detector.sv
// Coin gate front end: measure/classify occlusion, escrow FIFO, strobe to casher only on wait_ready.
// Strobe earliest one cycle after CLASS; never on adjacent cycles. COIN_DET_STATS_EN adds counters.
module coin_detector
    import coin_pkg::*;
#(
    parameter int MIN_W      = 8,
    parameter int T_5C       = 40,
    parameter int T_10C      = 48,
    parameter int T_25C      = 60,
    parameter int T_1D       = 70,
    parameter int T_2D       = 80,
    parameter int MAX_W      = 100,
    parameter int DEB_CYC    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coin_sensor,
    input  logic                      return_btn,
    input  logic                      wait_ready,
    output logic                      coin_insert,
    output logic [COIN_TYPE_BITS-1:0] coin_type,
    output logic                      return_coin,
    output logic                      escrow_flush,
    output logic                      coin_bounce,
    output logic                      jam
`ifdef COIN_DET_STATS_EN
    ,
    output logic [15:0]               coin_count,
    output logic [7:0]                bounce_count
`endif
);

    localparam int CNT_W = $clog2(MAX_W + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] MIN_W_C = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] T_5C_C  = CNT_W'(T_5C);
    localparam logic [CNT_W-1:0] T_10C_C = CNT_W'(T_10C);
    localparam logic [CNT_W-1:0] T_25C_C = CNT_W'(T_25C);
    localparam logic [CNT_W-1:0] T_1D_C  = CNT_W'(T_1D);
    localparam logic [CNT_W-1:0] T_2D_C  = CNT_W'(T_2D);
    localparam logic [CNT_W-1:0] MAX_W_C = CNT_W'(MAX_W);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic                      sens1_q, sens2_q;
    meas_state_t               state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      jam_q;
    coin_t                     class_type;
    logic                      class_ok, fifo_full, push, pop, serve_ret, slot_ok;
    logic                      ret_press;
    logic                      pend_q, pend_d;
    logic                      strobe_q;
    logic [COIN_TYPE_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0]          occ_q, occ_d;

    coin_debounce #(.DEB_CYC(DEB_CYC)) u_ret_deb (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (return_btn),
        .press_o (ret_press)
    );

    // Measure FSM; cnt stops at MAX_W+1 because that value forces JAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sens1_q <= 1'b0;
            sens2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            jam_q   <= 1'b0;
        end else begin
            sens1_q <= coin_sensor;
            sens2_q <= sens1_q;
            unique case (state_q)
                ST_IDLE: if (sens2_q) begin
                    state_q <= ST_MEAS;
                    cnt_q   <= CNT_W'(1);
                end
                ST_MEAS: if (cnt_q > MAX_W_C) begin
                    state_q <= ST_JAM;
                    jam_q   <= 1'b1;
                end else if (!sens2_q) begin
                    state_q <= ST_CLASS;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_CLASS: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                ST_JAM: if (!sens2_q) begin
                    state_q <= ST_IDLE;
                    jam_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        class_type = NONE;
        if      (cnt_q < T_5C_C)  class_type = C5;
        else if (cnt_q < T_10C_C) class_type = C10;
        else if (cnt_q < T_25C_C) class_type = C25;
        else if (cnt_q < T_1D_C)  class_type = D1;
        else if (cnt_q < T_2D_C)  class_type = D2;
    end

    assign class_ok  = (state_q == ST_CLASS) && (cnt_q >= MIN_W_C);
    assign fifo_full = (occ_q == OCC_FULL);
    assign push      = class_ok && !fifo_full;
    assign slot_ok   = wait_ready && !strobe_q;
    assign serve_ret = slot_ok && pend_q;
    assign pop       = slot_ok && !pend_q && (occ_q != '0);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        occ_d  = occ_q;
        pend_d = (pend_q && !serve_ret) || ret_press;
        if (serve_ret) begin
            // Flush also swallows a coin classified in this very cycle.
            wr_d  = '0;
            rd_d  = '0;
            occ_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            if (push && !pop)      occ_d = occ_q + 1'b1;
            else if (!push && pop) occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            pend_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            pend_q   <= pend_d;
            strobe_q <= pop || serve_ret;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !serve_ret) mem_q[wr_q] <= class_type;
    end

    assign coin_insert  = pop;
    assign coin_type    = pop ? mem_q[rd_q] : '0;
    assign return_coin  = serve_ret;
    assign escrow_flush = serve_ret;
    assign coin_bounce  = class_ok && fifo_full;
    assign jam          = jam_q;

`ifdef COIN_DET_STATS_EN
    logic [15:0] coin_cnt_q;
    logic [7:0]  bounce_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_cnt_q   <= '0;
            bounce_cnt_q <= '0;
        end else begin
            if (pop) coin_cnt_q <= coin_cnt_q + 16'd1;
            if (coin_bounce && bounce_cnt_q != 8'hFF) bounce_cnt_q <= bounce_cnt_q + 8'd1;
        end
    end

    assign coin_count   = coin_cnt_q;
    assign bounce_count = bounce_cnt_q;
`endif

endmodule

// File: tb/tb_coin_detector.sv
// Directed bench for coin_detector: classification boundaries, jam, escrow, return, reset.
module tb_coin_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_sensor = 1'b0;
    logic       return_btn = 1'b0;
    logic       wait_ready = 1'b0;
    logic       coin_insert, return_coin, escrow_flush, coin_bounce, jam;
    logic [2:0] coin_type;
`ifdef COIN_DET_STATS_EN
    logic [15:0] coin_count;
    logic [7:0]  bounce_count;
`endif

    coin_detector dut (
        .clk          (clk),
        .rst          (rst),
        .coin_sensor  (coin_sensor),
        .return_btn   (return_btn),
        .wait_ready   (wait_ready),
        .coin_insert  (coin_insert),
        .coin_type    (coin_type),
        .return_coin  (return_coin),
        .escrow_flush (escrow_flush),
        .coin_bounce  (coin_bounce),
        .jam          (jam)
`ifdef COIN_DET_STATS_EN
        ,
        .coin_count   (coin_count),
        .bounce_count (bounce_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int n_ins = 0, n_ret = 0, n_flush = 0, n_bounce = 0;
    int n_adj = 0, n_badtype = 0, n_rfmis = 0, n_both = 0;
    int last_type = -1;
    logic prev_strobe = 1'b0;
    logic strobe;
    assign strobe = coin_insert | return_coin;

    // Event monitor sampled on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            prev_strobe <= strobe;
            if (coin_insert) begin
                n_ins     <= n_ins + 1;
                last_type <= int'(coin_type);
            end else if (coin_type != 3'd0) begin
                n_badtype <= n_badtype + 1;
            end
            if (return_coin)                 n_ret    <= n_ret + 1;
            if (escrow_flush)                n_flush  <= n_flush + 1;
            if (return_coin != escrow_flush) n_rfmis  <= n_rfmis + 1;
            if (coin_insert && return_coin)  n_both   <= n_both + 1;
            if (coin_bounce)                 n_bounce <= n_bounce + 1;
            if (strobe && prev_strobe)       n_adj    <= n_adj + 1;
        end
    end

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic coin(input int w);
        coin_sensor = 1'b1;
        cyc(w);
        coin_sensor = 1'b0;
        cyc(8);
    endtask

    int widths [10] = '{7, 8, 39, 40, 47, 48, 60, 65, 79, 85};
    int exp_n  [10] = '{0, 1, 1,  1,  1,  1,  1,  1,  1,  1};
    int exp_t  [10] = '{0, 1, 1,  2,  2,  3,  4,  4,  5,  0};
    int b_ins, b_ret, b_flush, b_bounce;

    initial begin
        cyc(3);
        chk_eq("reset_outs", int'({coin_insert, coin_type, return_coin, escrow_flush, coin_bounce, jam}), 0);
        rst = 1'b0;
        cyc(3);

        // Classification boundaries with the casher ready.
        wait_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_ins = n_ins;
            coin(widths[i]);
            chk_eq($sformatf("width%0d_count", widths[i]), n_ins - b_ins, exp_n[i]);
            if (exp_n[i] == 1) chk_eq($sformatf("width%0d_type", widths[i]), last_type, exp_t[i]);
        end
        chk_eq("boundary_bounce", n_bounce, 0);

        // Noise pulse and jam.
        b_ins = n_ins;
        coin(5);
        chk_eq("noise_no_strobe", n_ins - b_ins, 0);
        coin_sensor = 1'b1;
        cyc(110);
        chk_eq("jam_set", int'(jam), 1);
        cyc(10);
        coin_sensor = 1'b0;
        cyc(6);
        chk_eq("jam_clear", int'(jam), 0);
        chk_eq("jam_no_push", n_ins - b_ins, 0);

        // Fill escrow, fifth coin bounces, drain with single-cycle wait_ready pulses.
        wait_ready = 1'b0;
        b_ins = n_ins;
        b_bounce = n_bounce;
        for (int i = 0; i < 5; i++) coin(45);
        chk_eq("full_bounce", n_bounce - b_bounce, 1);
        chk_eq("held_no_strobe", n_ins - b_ins, 0);
        for (int i = 0; i < 5; i++) begin
            wait_ready = 1'b1;
            cyc(1);
            wait_ready = 1'b0;
            cyc(2);
        end
        chk_eq("drain_count", n_ins - b_ins, 4);
        chk_eq("drain_type", last_type, 2);
`ifdef COIN_DET_STATS_EN
        chk_eq("stat_coins", int'(coin_count), n_ins);
        chk_eq("stat_bounces", int'(bounce_count), 1);
`endif

        // Continuous wait_ready: strobes spaced by at least one idle cycle.
        b_ins = n_ins;
        for (int i = 0; i < 3; i++) coin(45);
        wait_ready = 1'b1;
        cyc(10);
        chk_eq("burst_count", n_ins - b_ins, 3);

        // Return with two coins in escrow: flush instead of presenting.
        wait_ready = 1'b0;
        b_ins = n_ins;
        b_ret = n_ret;
        b_flush = n_flush;
        coin(45);
        coin(45);
        return_btn = 1'b1;
        cyc(20);
        return_btn = 1'b0;
        cyc(25);
        wait_ready = 1'b1;
        cyc(12);
        chk_eq("ret_count", n_ret - b_ret, 1);
        chk_eq("ret_flush", n_flush - b_flush, 1);
        chk_eq("ret_no_insert", n_ins - b_ins, 0);

        // Bouncy button never settles for long enough.
        b_ret = n_ret;
        for (int i = 0; i < 10; i++) begin
            return_btn = 1'b1;
            cyc(1);
            return_btn = 1'b0;
            cyc(3);
        end
        cyc(30);
        chk_eq("glitch_no_return", n_ret - b_ret, 0);

        // Long hold yields exactly one return.
        b_ret = n_ret;
        return_btn = 1'b1;
        cyc(60);
        return_btn = 1'b0;
        cyc(30);
        chk_eq("hold_one_return", n_ret - b_ret, 1);

        // Reset mid-measurement with three coins queued.
        wait_ready = 1'b0;
        for (int i = 0; i < 3; i++) coin(45);
        coin_sensor = 1'b1;
        cyc(20);
        rst = 1'b1;
        wait_ready = 1'b1;
        #1;
        chk_eq("rst_outs", int'({coin_insert, coin_type, return_coin, escrow_flush, coin_bounce, jam}), 0);
        coin_sensor = 1'b0;
        cyc(3);
        rst = 1'b0;
        b_ins = n_ins;
        b_ret = n_ret;
        b_bounce = n_bounce;
        cyc(20);
        chk_eq("post_rst_no_insert", n_ins - b_ins, 0);
        chk_eq("post_rst_quiet", (n_ret - b_ret) + (n_bounce - b_bounce), 0);
`ifdef COIN_DET_STATS_EN
        chk_eq("post_rst_coin_count", int'(coin_count), 0);
        chk_eq("post_rst_bounce_count", int'(bounce_count), 0);
`endif

        chk_eq("never_adjacent", n_adj, 0);
        chk_eq("type_zero_idle", n_badtype, 0);
        chk_eq("ret_flush_paired", n_rfmis, 0);
        chk_eq("ret_insert_exclusive", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
